// File: rtl/flappy_pkg.sv
// ---------------------------------------------------------------------------
// flappy_pkg
// Shared definitions for the pipe scroller and the pattern generator:
//   - scrollState_t : play state of the scroller {IDLE, RUN, HALT, DONE}
//   - SCREEN_W, SPACING, BIRD_X : default course geometry (pixels)
//   - END_GAP       : gap value that marks the final (sentinel) pipe
//   - wrapValue()   : position a pipe jumps to after it has sat at x=0
// ---------------------------------------------------------------------------
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        DONE = 2'd3
    } scrollState_t;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SPACING  = 320;
    localparam int unsigned BIRD_X   = 160;
    localparam int unsigned END_GAP  = 395;

    // Two pipes share one 2*SPACING period, so a pipe leaving x=0 re-enters
    // one spacing behind its partner.
    function automatic logic [15:0] wrapValue(input int unsigned spacing);
        return 16'((2 * spacing) - 1);
    endfunction

endpackage

// File: rtl/pipe_lane.sv
// ---------------------------------------------------------------------------
// pipe_lane
// One scrolling pipe column: position counter with wrap, and the gap latch.
// Ports:
//   clk       in  1  : system clock
//   Reset     in  1  : asynchronous active-low reset
//   advance   in  1  : move one pixel left this cycle (already qualified by
//                      the top-level play state)
//   startLoad in  1  : latch nextGap at game start
//   nextGap   in  16 : gap height offered by the pattern generator
//   pos       out 16 : current x of this pipe
//   gap       out 16 : latched gap height of this pipe
//   hitBird   out 1  : strobe, this advance moves the pipe past the bird
// ---------------------------------------------------------------------------
module pipe_lane #(
    parameter logic [15:0] INIT_POS = 16'(flappy_pkg::SCREEN_W),
    parameter logic [15:0] WRAP_POS = flappy_pkg::wrapValue(flappy_pkg::SPACING),
    parameter logic [15:0] BIRD_POS = 16'(flappy_pkg::BIRD_X)
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        advance,
    input  logic        startLoad,
    input  logic [15:0] nextGap,
    output logic [15:0] pos,
    output logic [15:0] gap,
    output logic        hitBird
);

    // Position counter. The pipe is deliberately left at 0 for a whole step
    // period before wrapping, so the pattern generator can see pos == 0 and
    // present the next gap before it is latched on the wrapping step.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            pos <= INIT_POS;
        end else if (advance) begin
            if (pos == 16'd0) begin
                pos <= WRAP_POS;
            end else begin
                pos <= pos - 16'd1;
            end
        end
    end

    // Gap latch: loaded once at start, then on every wrap with whatever the
    // generator is offering in that same cycle.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            gap <= 16'd0;
        end else if (startLoad || (advance && (pos == 16'd0))) begin
            gap <= nextGap;
        end
    end

    // The pipe scores on the step that moves it off the bird's column.
    assign hitBird = advance && (pos == BIRD_POS);

endmodule

// File: rtl/pipe_scroller.sv
// ---------------------------------------------------------------------------
// pipe_scroller
// Consumer of the pipe-height pattern: scrolls two pipes, latches their gaps,
// counts score and detects the end-of-course sentinel pipe.
// Ports:
//   clk            in  1  : system clock
//   Reset          in  1  : asynchronous active-low reset
//   Step           in  1  : one-cycle scroll strobe
//   Button         in  1  : active-low start
//   Collide        in  1  : level, freezes play
//   Pattern1/2     in  16 : next gap height for pipe 1 / pipe 2
//   PipesPosition1/2 out 16 : x of pipe 1 / pipe 2
//   Gap1/2         out 16 : latched gap of pipe 1 / pipe 2
//   Score          out 8  : saturating count of pipes passed
//   ScoreTick      out 1  : one-cycle pulse per scoring step
//   Finished       out 1  : sticky, sentinel pipe has passed the bird
// ---------------------------------------------------------------------------
module pipe_scroller
    import flappy_pkg::*;
#(
    parameter int unsigned SCREEN_W = flappy_pkg::SCREEN_W,
    parameter int unsigned SPACING  = flappy_pkg::SPACING,
    parameter int unsigned BIRD_X   = flappy_pkg::BIRD_X,
    parameter int unsigned END_GAP  = flappy_pkg::END_GAP
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Step,
    input  logic        Button,
    input  logic        Collide,
    input  logic [15:0] Pattern1,
    input  logic [15:0] Pattern2,
    output logic [15:0] PipesPosition1,
    output logic [15:0] PipesPosition2,
    output logic [15:0] Gap1,
    output logic [15:0] Gap2,
    output logic [7:0]  Score,
    output logic        ScoreTick,
    output logic        Finished
);

    localparam logic [15:0] END_GAP_V = 16'(END_GAP);

    scrollState_t state;
    scrollState_t nextState;

    logic       advance;
    logic       startLoad;
    logic       hit1;
    logic       hit2;
    logic       sentinel1;
    logic       sentinel2;
    logic       sentinelHit;
    logic [1:0] scoreHits;
    logic [8:0] scoreSum;

    pipe_lane #(
        .INIT_POS (16'(SCREEN_W)),
        .WRAP_POS (wrapValue(SPACING)),
        .BIRD_POS (16'(BIRD_X))
    ) u_lane1 (
        .clk       (clk),
        .Reset     (Reset),
        .advance   (advance),
        .startLoad (startLoad),
        .nextGap   (Pattern1),
        .pos       (PipesPosition1),
        .gap       (Gap1),
        .hitBird   (hit1)
    );

    pipe_lane #(
        .INIT_POS (16'(SCREEN_W + SPACING)),
        .WRAP_POS (wrapValue(SPACING)),
        .BIRD_POS (16'(BIRD_X))
    ) u_lane2 (
        .clk       (clk),
        .Reset     (Reset),
        .advance   (advance),
        .startLoad (startLoad),
        .nextGap   (Pattern2),
        .pos       (PipesPosition2),
        .gap       (Gap2),
        .hitBird   (hit2)
    );

    // A pipe passing the bird with the sentinel gap ends the course instead
    // of scoring; any other passing pipe adds one to the score.
    assign sentinel1   = hit1 && (Gap1 == END_GAP_V);
    assign sentinel2   = hit2 && (Gap2 == END_GAP_V);
    assign sentinelHit = sentinel1 || sentinel2;
    assign scoreHits   = {1'b0, hit1 && !sentinel1} + {1'b0, hit2 && !sentinel2};
    assign scoreSum    = {1'b0, Score} + {7'd0, scoreHits};

    // State register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. Collide is checked before the step so a collision
    // in the same cycle as a step wins. HALT and DONE only leave on reset.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (!Button) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (Collide) begin
                    nextState = HALT;
                end else if (Step && sentinelHit) begin
                    nextState = DONE;
                end
            end
            HALT:    nextState = HALT;
            DONE:    nextState = DONE;
            default: nextState = IDLE;
        endcase
    end

    // Output decode: qualify the raw strobes by play state for the lanes.
    always_comb begin
        advance   = 1'b0;
        startLoad = 1'b0;
        case (state)
            IDLE:    startLoad = !Button;
            RUN:     advance   = Step && !Collide;
            default: begin
                advance   = 1'b0;
                startLoad = 1'b0;
            end
        endcase
    end

    // Score saturator and tick. The tick fires for every scoring step, even
    // once the count has saturated at 255.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            Score     <= 8'd0;
            ScoreTick <= 1'b0;
        end else begin
            ScoreTick <= 1'b0;
            if (advance && !sentinelHit && (scoreHits != 2'd0)) begin
                Score     <= scoreSum[8] ? 8'hFF : scoreSum[7:0];
                ScoreTick <= 1'b1;
            end
        end
    end

    // Sticky end-of-course flag, set on the same edge the FSM enters DONE.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            Finished <= 1'b0;
        end else if (advance && sentinelHit) begin
            Finished <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_scroller.sv
// ---------------------------------------------------------------------------
// tb_pipe_scroller
// Two instances: dutA with the default course geometry, dutB with a tiny
// geometry so the score can reach saturation in a short run. A reference
// model computes pipe positions in closed form from the number of steps
// taken, and tracks gaps, score and play state from the game rules.
// ---------------------------------------------------------------------------
module tb_pipe_scroller;

    localparam int END_GAP = 395;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;
    localparam int M_DONE = 3;

    logic        clk;
    logic        resetN   [2];
    logic        stepS    [2];
    logic        buttonN  [2];
    logic        collideS [2];
    logic [15:0] pat1     [2];
    logic [15:0] pat2     [2];
    logic [15:0] pos1     [2];
    logic [15:0] pos2     [2];
    logic [15:0] gap1     [2];
    logic [15:0] gap2     [2];
    logic [7:0]  score    [2];
    logic        tick     [2];
    logic        fin      [2];

    int geoW [2] = '{640, 8};
    int geoS [2] = '{320, 4};
    int geoB [2] = '{160, 2};

    int mMode  [2];
    int mAdv   [2];
    int mGap1  [2];
    int mGap2  [2];
    int mScore [2];
    bit mTick  [2];
    bit mFin   [2];

    int testCount = 0;
    int failCount = 0;
    int forceP2   = -1;

    pipe_scroller dutA (
        .clk            (clk),
        .Reset          (resetN[0]),
        .Step           (stepS[0]),
        .Button         (buttonN[0]),
        .Collide        (collideS[0]),
        .Pattern1       (pat1[0]),
        .Pattern2       (pat2[0]),
        .PipesPosition1 (pos1[0]),
        .PipesPosition2 (pos2[0]),
        .Gap1           (gap1[0]),
        .Gap2           (gap2[0]),
        .Score          (score[0]),
        .ScoreTick      (tick[0]),
        .Finished       (fin[0])
    );

    pipe_scroller #(
        .SCREEN_W (8),
        .SPACING  (4),
        .BIRD_X   (2),
        .END_GAP  (395)
    ) dutB (
        .clk            (clk),
        .Reset          (resetN[1]),
        .Step           (stepS[1]),
        .Button         (buttonN[1]),
        .Collide        (collideS[1]),
        .Pattern1       (pat1[1]),
        .Pattern2       (pat2[1]),
        .PipesPosition1 (pos1[1]),
        .PipesPosition2 (pos2[1]),
        .Gap1           (gap1[1]),
        .Gap2           (gap2[1]),
        .Score          (score[1]),
        .ScoreTick      (tick[1]),
        .Finished       (fin[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a wedged run still ends.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Pipe x after k steps: counts down from p0 to 0, then cycles through
    // 2*s-1 .. 0 forever.
    function automatic int lanePos(input int p0, input int k, input int s);
        if (k <= p0) return p0 - k;
        return (2 * s - 1) - ((k - p0 - 1) % (2 * s));
    endfunction

    task automatic modelReset(input int i);
        mMode[i]  = M_IDLE;
        mAdv[i]   = 0;
        mGap1[i]  = 0;
        mGap2[i]  = 0;
        mScore[i] = 0;
        mTick[i]  = 1'b0;
        mFin[i]   = 1'b0;
    endtask

    // Effect of one clock edge with the given inputs on the game.
    task automatic modelEdge(input int i, input bit st, input bit btn,
                             input bit col, input int p1, input int p2);
        int x1;
        int x2;
        int hits;
        bit sentinel;
        mTick[i] = 1'b0;
        if (mMode[i] == M_IDLE) begin
            if (btn) begin
                mGap1[i] = p1;
                mGap2[i] = p2;
                mMode[i] = M_RUN;
            end
        end else if (mMode[i] == M_RUN) begin
            if (col) begin
                mMode[i] = M_HALT;
            end else if (st) begin
                x1 = lanePos(geoW[i], mAdv[i], geoS[i]);
                x2 = lanePos(geoW[i] + geoS[i], mAdv[i], geoS[i]);
                hits = 0;
                sentinel = 1'b0;
                if (x1 == geoB[i]) begin
                    if (mGap1[i] == END_GAP) sentinel = 1'b1;
                    else hits++;
                end
                if (x2 == geoB[i]) begin
                    if (mGap2[i] == END_GAP) sentinel = 1'b1;
                    else hits++;
                end
                if (x1 == 0) mGap1[i] = p1;
                if (x2 == 0) mGap2[i] = p2;
                mAdv[i]++;
                if (sentinel) begin
                    mFin[i]  = 1'b1;
                    mMode[i] = M_DONE;
                end else if (hits > 0) begin
                    mScore[i] = (mScore[i] + hits > 255) ? 255 : mScore[i] + hits;
                    mTick[i]  = 1'b1;
                end
            end
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input int i, input string tag);
        checkVal($sformatf("%s[%0d] pos1", tag, i), 32'(pos1[i]),
                 32'(lanePos(geoW[i], mAdv[i], geoS[i])));
        checkVal($sformatf("%s[%0d] pos2", tag, i), 32'(pos2[i]),
                 32'(lanePos(geoW[i] + geoS[i], mAdv[i], geoS[i])));
        checkVal($sformatf("%s[%0d] gap1", tag, i), 32'(gap1[i]), 32'(mGap1[i]));
        checkVal($sformatf("%s[%0d] gap2", tag, i), 32'(gap2[i]), 32'(mGap2[i]));
        checkVal($sformatf("%s[%0d] score", tag, i), 32'(score[i]), 32'(mScore[i]));
        checkVal($sformatf("%s[%0d] tick", tag, i), 32'(tick[i]), 32'(mTick[i]));
        checkVal($sformatf("%s[%0d] finished", tag, i), 32'(fin[i]), 32'(mFin[i]));
    endtask

    // Called at a falling edge: drive inputs for one rising edge, update the
    // model, then return the strobes to idle at the next falling edge.
    task automatic applyStimulus(input int i, input bit st, input bit btn,
                                 input bit col, input int p1, input int p2);
        stepS[i]    = st;
        buttonN[i]  = ~btn;
        collideS[i] = col;
        pat1[i]     = 16'(p1);
        pat2[i]     = 16'(p2);
        modelEdge(i, st, btn, col, p1, p2);
        @(negedge clk);
        stepS[i]    = 1'b0;
        buttonN[i]  = 1'b1;
        collideS[i] = 1'b0;
    endtask

    // One step with given patterns, checked, then 3..5 idle cycles so the
    // strobe rate stays within one per four clocks; the tick must drop.
    task automatic doStepPat(input int i, input bit col, input int p1, input int p2);
        int nIdle;
        applyStimulus(i, 1'b1, 1'b0, col, p1, p2);
        checkOutput(i, "step");
        nIdle = int'($urandom_range(3, 5));
        for (int n = 0; n < nIdle; n++) begin
            applyStimulus(i, 1'b0, 1'b0, 1'b0, int'($urandom_range(0, 394)),
                          int'($urandom_range(0, 394)));
            if (n == 0) checkOutput(i, "idle");
        end
    endtask

    task automatic doStep(input int i, input bit col);
        int p2;
        p2 = (forceP2 >= 0 && i == 0) ? forceP2 : int'($urandom_range(0, 394));
        doStepPat(i, col, int'($urandom_range(0, 394)), p2);
    endtask

    // Reset asserted a little after a falling edge, i.e. between rising
    // edges, and checked before the next rising edge.
    task automatic doReset(input int i);
        @(negedge clk);
        #1;
        resetN[i] = 1'b0;
        modelReset(i);
        #1;
        checkOutput(i, "reset");
        @(negedge clk);
        resetN[i] = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            resetN[i]   = 1'b1;
            stepS[i]    = 1'b0;
            buttonN[i]  = 1'b1;
            collideS[i] = 1'b0;
            pat1[i]     = 16'd0;
            pat2[i]     = 16'd0;
            modelReset(i);
        end

        doReset(0);
        doReset(1);
        checkVal("reset pos1", 32'(pos1[0]), 32'd640);
        checkVal("reset pos2", 32'(pos2[0]), 32'd960);

        // Step is ignored in IDLE.
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 7, 9);
        checkOutput(0, "idle step");

        // Start with known patterns.
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 80, 140);
        checkOutput(0, "start");
        checkVal("start gap1", 32'(gap1[0]), 32'd80);
        checkVal("start gap2", 32'(gap2[0]), 32'd140);

        // Scroll pipe 1 down to x=0; it passes the bird once on the way.
        repeat (640) doStep(0, 1'b0);
        checkVal("pos1 at zero", 32'(pos1[0]), 32'd0);
        checkVal("pos2 at 320", 32'(pos2[0]), 32'd320);
        checkVal("score after first pass", 32'(score[0]), 32'd1);

        // Wrap with a chosen pattern.
        doStepPat(0, 1'b0, 110, int'($urandom_range(0, 394)));
        checkVal("wrap pos1", 32'(pos1[0]), 32'd639);
        checkVal("wrap gap1", 32'(gap1[0]), 32'd110);

        // Pipe 2 picks up the sentinel gap on its wrap; run until it passes.
        forceP2 = END_GAP;
        for (int n = 0; n < 2000 && !mFin[0]; n++) doStep(0, 1'b0);
        checkVal("sentinel finished", 32'(fin[0]), 32'd1);
        checkVal("sentinel score", 32'(score[0]), 32'd3);
        forceP2 = -1;
        repeat (5) doStep(0, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 1, 2);
        checkOutput(0, "done button");

        // Collision in the same cycle as a step.
        doReset(0);
        applyStimulus(0, 1'b0, 1'b1, 1'b0, int'($urandom_range(0, 394)),
                      int'($urandom_range(0, 394)));
        repeat (25) doStep(0, 1'b0);
        doStep(0, 1'b1);
        checkVal("collide pos1", 32'(pos1[0]), 32'd615);
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 3, 4);
        checkOutput(0, "halt button");
        repeat (3) doStep(0, 1'b0);

        // Asynchronous reset in the middle of a run.
        doReset(0);
        applyStimulus(0, 1'b0, 1'b1, 1'b0, int'($urandom_range(0, 394)),
                      int'($urandom_range(0, 394)));
        repeat (30) doStep(0, 1'b0);
        doReset(0);
        checkVal("midrun reset pos1", 32'(pos1[0]), 32'd640);
        checkVal("midrun reset score", 32'(score[0]), 32'd0);

        // Saturation on the small-geometry instance.
        doReset(1);
        applyStimulus(1, 1'b0, 1'b1, 1'b0, int'($urandom_range(0, 394)),
                      int'($urandom_range(0, 394)));
        for (int n = 0; n < 1500 && mScore[1] < 255; n++) doStep(1, 1'b0);
        repeat (40) doStep(1, 1'b0);
        checkVal("saturated score", 32'(score[1]), 32'd255);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
